// File: rtl/pong_score_ctrl.sv
// pong_score_ctrl: PONG match sequencer.
// Keeps two BCD score registers, arbitrates goal events, paces serves by
// frame ticks and flags the end of the match. All outputs are registered.
module pong_score_ctrl #(
  parameter logic [7:0] WIN_SCORE    = 8'h11,
  parameter int         SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       point_l,
  input  logic       point_r,
  output logic [7:0] score_l,
  output logic [7:0] score_r,
  output logic       ball_en,
  output logic       serve_dir,
  output logic       game_over,
  output logic       winner
);

  localparam int CW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_FRAMES - 1);

  typedef enum logic [2:0] {S_IDLE, S_SERVE, S_PLAY, S_CHECK, S_OVER} state_t;

  state_t        state_q, state_d;
  logic [7:0]    score_l_q, score_l_d;
  logic [7:0]    score_r_q, score_r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rr_q, rr_d;
  logic          ball_en_q, ball_en_d;
  logic          serve_dir_q, serve_dir_d;
  logic          game_over_q, game_over_d;
  logic          winner_q, winner_d;

  // Two-digit BCD increment; ones carry into tens, 99 saturates.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)
      return v;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'h0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Point arbitration: a lone pulse wins outright, a collision goes to rr_q
  // (0 = left). gnt_side uses the same 0=left/1=right encoding as winner.
  logic pt_any, pt_both, gnt_side;
  assign pt_any   = point_l | point_r;
  assign pt_both  = point_l & point_r;
  assign gnt_side = pt_both ? rr_q : point_r;

  // In CHECK the side that just scored is recoverable from serve_dir
  // (serve goes toward the player who conceded), so no extra register.
  logic       chk_side;
  logic [7:0] chk_score;
  logic       win_hit;
  assign chk_side  = ~serve_dir_q;
  assign chk_score = chk_side ? score_r_q : score_l_q;
  assign win_hit   = (chk_score == WIN_SCORE);

  // State and datapath registers; clr wins over everything.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= S_IDLE;
      score_l_q   <= 8'h00;
      score_r_q   <= 8'h00;
      cnt_q       <= '0;
      rr_q        <= 1'b0;
      ball_en_q   <= 1'b0;
      serve_dir_q <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      ball_en_q   <= ball_en_d;
      serve_dir_q <= serve_dir_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  // Next-state logic for the match sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_OVER: if (start) state_d = S_SERVE;
      S_SERVE:        if (frame_tick && cnt_q == CNT_LAST) state_d = S_PLAY;
      S_PLAY:         if (pt_any) state_d = S_CHECK;
      S_CHECK:        state_d = win_hit ? S_OVER : S_SERVE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Next values of scores, counter and registered outputs.
  always_comb begin
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    serve_dir_d = serve_dir_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          score_l_d   = 8'h00;
          score_r_d   = 8'h00;
          cnt_d       = '0;
          game_over_d = 1'b0;
          winner_d    = 1'b0;
        end
      end
      S_SERVE: begin
        if (frame_tick)
          cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
      end
      S_PLAY: begin
        if (pt_any) begin
          if (gnt_side) score_r_d = bcd_inc(score_r_q);
          else          score_l_d = bcd_inc(score_l_q);
          serve_dir_d = ~gnt_side;
          if (pt_both) rr_d = ~gnt_side;
        end
      end
      S_CHECK: begin
        cnt_d = '0;
        if (win_hit) begin
          game_over_d = 1'b1;
          winner_d    = chk_side;
        end
      end
      default: ;
    endcase
    ball_en_d = (state_d == S_PLAY);
  end

  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign ball_en   = ball_en_q;
  assign serve_dir = serve_dir_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule
